// File: rtl/cpu_int_ctrl.sv
`default_nettype none
// ============================================================================
// cpu_int_ctrl : interrupt arbiter and vector generator for the 65816 core
// Rev 1.0 - initial release
// ============================================================================
module cpu_int_ctrl #(
  parameter int                      NUM_SRC    = 5,
  parameter logic [NUM_SRC-1:0]      EDGE_MASK  = 5'b00010,
  parameter logic [NUM_SRC-1:0]      MASKABLE   = 5'b00100,
  parameter logic [NUM_SRC*16-1:0]   VEC_NATIVE = {16'hffe4, 16'hffe6, 16'hffee, 16'hffea, 16'hfffc},
  parameter logic [NUM_SRC*16-1:0]   VEC_EMU    = {16'hfff4, 16'hfffe, 16'hfffe, 16'hfffa, 16'hfffc},
  localparam int                     ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_en,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               i_flag,
  input  logic               e,
  input  logic               ack,
  input  logic               done,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service,
  output logic [23:0]        vector_addr
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SERVICE = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pend;
  logic [ID_W-1:0]    r_id;
  logic               r_e;

  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [ID_W-1:0]    w_sel;
  logic               w_take;
  logic               w_use_e;
  logic [15:0]        w_entry;

  assign w_elig = r_pend & ~(MASKABLE & {NUM_SRC{i_flag}});

  // Lowest set bit wins: scan downwards so the last hit is the lowest index.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = ID_W'(i);
    end
  end

  // Edge bits: a new rising edge overrides an ack-clear in the same cycle.
  // Level bits simply track the line one cycle late and ignore ack.
  assign w_clr      = w_take ? (NUM_SRC'(1) << w_sel) : '0;
  assign w_pend_nxt = (EDGE_MASK & ((r_pend & ~w_clr) | (src_in & ~r_src_q)))
                    | (~EDGE_MASK & src_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (cpu_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    int_req     = 1'b0;
    in_service  = 1'b0;
    w_take      = 1'b0;
    int_id      = '0;
    w_use_e     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        int_req = |w_elig;
        int_id  = w_sel;
        w_use_e = e;
        if (ack && int_req && cpu_en) begin
          w_take      = 1'b1;
          w_state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        in_service = 1'b1;
        int_id     = r_id;
        w_use_e    = r_e;
        if (done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_q <= '0;
      r_pend  <= '0;
      r_id    <= '0;
      r_e     <= 1'b0;
    end else if (cpu_en) begin
      r_src_q <= src_in;
      r_pend  <= w_pend_nxt;
      if (w_take) begin
        r_id <= w_sel;
        r_e  <= e;
      end
    end
  end

  always_comb begin
    w_entry = 16'h0000;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int_id == ID_W'(i)) w_entry = w_use_e ? VEC_EMU[16*i +: 16] : VEC_NATIVE[16*i +: 16];
    end
  end

  // An idle block with nothing eligible reports a zero vector.
  assign vector_addr = (!in_service && !int_req) ? 24'h000000 : {8'h00, w_entry};

endmodule
`default_nettype wire

// File: tb/tb_cpu_int_ctrl.sv
`default_nettype none
// tb_cpu_int_ctrl : directed self-checking bench for cpu_int_ctrl.
module tb_cpu_int_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic [4:0]  src_in;
  logic        i_flag;
  logic        e;
  logic        ack;
  logic        done;
  logic        int_req;
  logic [2:0]  int_id;
  logic        in_service;
  logic [23:0] vector_addr;

  int n_checks = 0;
  int n_errors = 0;

  cpu_int_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_en      (cpu_en),
    .src_in      (src_in),
    .i_flag      (i_flag),
    .e           (e),
    .ack         (ack),
    .done        (done),
    .int_req     (int_req),
    .int_id      (int_id),
    .in_service  (in_service),
    .vector_addr (vector_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_all(input string tag, input logic rq, input logic [2:0] id,
                           input logic sv, input logic [23:0] va);
    check({tag, ".int_req"},     32'(int_req),     32'(rq));
    check({tag, ".int_id"},      32'(int_id),      32'(id));
    check({tag, ".in_service"},  32'(in_service),  32'(sv));
    check({tag, ".vector_addr"}, 32'(vector_addr), 32'(va));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cpu_en = 1'b1; src_in = 5'b0; i_flag = 1'b0;
    e = 1'b0; ack = 1'b0; done = 1'b0;
    cyc(); cyc();
    settle(); check_all("reset", 1'b0, 3'd0, 1'b0, 24'h000000);

    // Reset priority: NMI (edge) beats IRQ (level).
    reset = 1'b0; src_in = 5'b00110;
    cyc(); settle();
    check_all("prio", 1'b1, 3'd1, 1'b0, 24'h00ffea);
    ack = 1'b1;
    cyc(); ack = 1'b0; settle();
    check_all("prio_svc", 1'b0, 3'd1, 1'b1, 24'h00ffea);
    done = 1'b1;
    cyc(); done = 1'b0; settle();
    check_all("prio_after", 1'b1, 3'd2, 1'b0, 24'h00ffee);

    // Masking is combinational on i_flag; e selects the emulation table.
    src_in = 5'b00100; i_flag = 1'b1; settle();
    check_all("masked", 1'b0, 3'd0, 1'b0, 24'h000000);
    i_flag = 1'b0; e = 1'b1; settle();
    check_all("unmasked_emu", 1'b1, 3'd2, 1'b0, 24'h00fffe);
    src_in = 5'b0; e = 1'b0;
    cyc(); settle();
    check("irq_drop.int_req", 32'(int_req), 32'd0);

    // NMI pulse during BRK service stays pending.
    src_in = 5'b01000;
    cyc(); settle();
    check_all("brk", 1'b1, 3'd3, 1'b0, 24'h00ffe6);
    ack = 1'b1;
    cyc(); ack = 1'b0; src_in = 5'b00010; settle();
    check_all("brk_svc", 1'b0, 3'd3, 1'b1, 24'h00ffe6);
    cyc(); src_in = 5'b0; settle();
    check("brk_svc_hold.int_id", 32'(int_id), 32'd3);
    done = 1'b1;
    cyc(); done = 1'b0; settle();
    check_all("nmi_pending", 1'b1, 3'd1, 1'b0, 24'h00ffea);

    // Set beats clear: ack of NMI while a fresh NMI edge is sampled.
    ack = 1'b1; src_in = 5'b00010;
    cyc(); ack = 1'b0; src_in = 5'b0; settle();
    check_all("setclr_svc", 1'b0, 3'd1, 1'b1, 24'h00ffea);
    done = 1'b1;
    cyc(); done = 1'b0; settle();
    check_all("setclr_after", 1'b1, 3'd1, 1'b0, 24'h00ffea);
    ack = 1'b1;
    cyc(); ack = 1'b0; done = 1'b1;
    cyc(); done = 1'b0; settle();
    check("nmi_cleared.int_req", 32'(int_req), 32'd0);

    // Mode latch: e captured at ack for COP.
    src_in = 5'b10000;
    cyc(); settle();
    check_all("cop", 1'b1, 3'd4, 1'b0, 24'h00ffe4);
    ack = 1'b1;
    cyc(); ack = 1'b0; e = 1'b1; src_in = 5'b0; settle();
    check_all("cop_svc_e1", 1'b0, 3'd4, 1'b1, 24'h00ffe4);
    cyc(); e = 1'b0; settle();
    check("cop_svc_e0.vector_addr", 32'(vector_addr), 32'h00ffe4);
    e = 1'b1; settle();
    check("cop_svc_e1b.vector_addr", 32'(vector_addr), 32'h00ffe4);
    done = 1'b1;
    cyc(); done = 1'b0; e = 1'b0; settle();
    check_all("cop_after", 1'b0, 3'd0, 1'b0, 24'h000000);

    // ack with nothing pending and done in IDLE are both ignored.
    ack = 1'b1; done = 1'b1;
    cyc(); ack = 1'b0; done = 1'b0; settle();
    check_all("stray_ack", 1'b0, 3'd0, 1'b0, 24'h000000);

    // cpu_en=0 freezes the edge latch.
    cpu_en = 1'b0; src_in = 5'b00010;
    cyc(); cyc(); settle();
    check("noen.int_req", 32'(int_req), 32'd0);
    src_in = 5'b0;
    cyc(); cpu_en = 1'b1;
    cyc(); settle();
    check("noen_after.int_req", 32'(int_req), 32'd0);

    // Reset in SERVICE, then an edge source already high at release.
    src_in = 5'b00010;
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0; settle();
    check("pre_rst.in_service", 32'(in_service), 32'd1);
    reset = 1'b1;
    cyc(); settle();
    check_all("mid_rst", 1'b0, 3'd0, 1'b0, 24'h000000);
    reset = 1'b0;
    cyc(); settle();
    check_all("rst_release_edge", 1'b1, 3'd1, 1'b0, 24'h00ffea);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
